// File: rtl/div_gen_1_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } div_state_t;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_gen_1_if.sv
// Start/operand/result bundle between the execute stage and the divider.
interface div_gen_1_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (
    output div, A, B,
    input  Q, R, busy, done, dbz
  );

  modport slave (
    input  div, A, B,
    output Q, R, busy, done, dbz
  );
endinterface

// File: rtl/div_gen_1_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_sh   = {rem[WIDTH-1:0], din};
    diff     = rem_sh - {1'b0, divisor};
    qbit     = 1'b0;
    rem_next = rem_sh;
    if (rem_sh >= {1'b0, divisor}) begin
      qbit     = 1'b1;
      rem_next = diff;
    end
  end

endmodule

// File: rtl/div_gen_1.sv
// Sequential unsigned divider, one quotient bit per clock (restoring, radix-2).
module div_gen_1
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic        CLK,
  input logic        RESETN,
  div_gen_1_if.slave bus
);

  localparam int unsigned CW = clog2(WIDTH) + 1;

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] qsh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_nxt;
  logic             qbit;
  logic             dbz_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .din      (qsh[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_nxt),
    .qbit     (qbit)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      count    <= '0;
      qsh      <= '0;
      dvs      <= '0;
      rem      <= '0;
      dbz_r    <= 1'b0;
      bus.Q    <= '0;
      bus.R    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dbz  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.div) begin
            if (bus.B != '0) begin
              qsh      <= bus.A;
              dvs      <= bus.B;
              rem      <= '0;
              count    <= CW'(WIDTH);
              dbz_r    <= 1'b0;
              bus.busy <= 1'b1;
              state    <= CALC;
            end else begin
              // Divide-by-zero skips CALC; FIN publishes the preloaded result.
              qsh   <= '1;
              rem   <= {1'b0, bus.A};
              dvs   <= '0;
              dbz_r <= 1'b1;
              state <= FIN;
            end
          end
        end
        CALC: begin
          rem   <= rem_nxt;
          qsh   <= {qsh[WIDTH-2:0], qbit};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bus.busy <= 1'b0;
            state    <= FIN;
          end
        end
        FIN: begin
          bus.Q    <= qsh;
          bus.R    <= rem[WIDTH-1:0];
          bus.dbz  <= dbz_r;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_gen_1.sv
// Directed bench for div_gen_1 (WIDTH=32) with immediate-assertion checks.
module tb_div_gen_1;

  localparam int unsigned W = 32;

  logic CLK;
  logic RESETN;
  int   tests;
  int   failed;

  div_gen_1_if #(.WIDTH(W)) bus ();

  div_gen_1 #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulses div for one edge; returns just after the accepting edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.div = 1'b1;
    bus.A   = a;
    bus.B   = b;
    tick();
    bus.div = 1'b0;
  endtask

  // Counts edges until done; checks Q holds its old value mid-calculation.
  task automatic wait_done(input int limit, input logic [W-1:0] held_q, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (i == 16) chk("q_hold_mid_calc", 64'(bus.Q), 64'(held_q));
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                     input int elat);
    int n;
    logic [W-1:0] held;
    held = bus.Q;
    start(a, b);
    chk({tag, "_busy_start"}, 64'(bus.busy), 64'(b != '0));
    wait_done(40, held, n);
    chk({tag, "_latency"}, 64'(n), 64'(elat));
    chk({tag, "_Q"}, 64'(bus.Q), 64'(eq));
    chk({tag, "_R"}, 64'(bus.R), 64'(er));
    chk({tag, "_dbz"}, 64'(bus.dbz), 64'(edbz));
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  logic [W-1:0] ea [6];
  logic [W-1:0] eb [6];
  logic [W-1:0] eq [6];
  logic [W-1:0] er [6];

  initial begin
    int n;
    logic seen;
    logic [W-1:0] ra, rb;
    tests   = 0;
    failed  = 0;
    RESETN  = 1'b0;
    bus.div = 1'b0;
    bus.A   = '0;
    bus.B   = '0;
    repeat (3) tick();
    chk("reset_Q", 64'(bus.Q), 64'd0);
    chk("reset_R", 64'(bus.R), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dbz", 64'(bus.dbz), 64'd0);
    RESETN = 1'b1;
    tick();

    run("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run("ff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run("ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
    run("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
    run("d0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
    run("dbz5", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // A second div during CALC must be ignored.
    start(32'd1000, 32'd10);
    repeat (4) tick();
    bus.div = 1'b1;
    bus.A   = 32'd1;
    bus.B   = 32'd1;
    tick();
    bus.div = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done) begin
        n = i;
        break;
      end
    end
    chk("ign_latency", 64'(n), 64'd28);
    chk("ign_Q", 64'(bus.Q), 64'd100);
    chk("ign_R", 64'(bus.R), 64'd0);
    run("b2b_7_2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);

    // Asynchronous reset mid-CALC.
    start(32'd1000, 32'd10);
    repeat (11) tick();
    #3;
    RESETN = 1'b0;
    #1;
    chk("arst_Q", 64'(bus.Q), 64'd0);
    chk("arst_R", 64'(bus.R), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    repeat (2) tick();
    RESETN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("arst_no_done", 64'(seen), 64'd0);
    run("d50_6", 32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 33);

    // Edge operands with hand-computed results.
    ea[0] = 32'd0;          eb[0] = 32'd1;          eq[0] = 32'd0;          er[0] = 32'd0;
    ea[1] = 32'd1;          eb[1] = 32'hFFFF_FFFF;  eq[1] = 32'd0;          er[1] = 32'd1;
    ea[2] = 32'h8000_0000;  eb[2] = 32'd1;          eq[2] = 32'h8000_0000;  er[2] = 32'd0;
    ea[3] = 32'hFFFF_FFFF;  eb[3] = 32'h8000_0000;  eq[3] = 32'd1;          er[3] = 32'h7FFF_FFFF;
    ea[4] = 32'h8000_0000;  eb[4] = 32'hFFFF_FFFF;  eq[4] = 32'd0;          er[4] = 32'h8000_0000;
    ea[5] = 32'hFFFF_FFFF;  eb[5] = 32'd2;          eq[5] = 32'h7FFF_FFFF;  er[5] = 32'd1;
    for (int i = 0; i < 6; i++) begin
      run($sformatf("edge%0d", i), ea[i], eb[i], eq[i], er[i], 1'b0, 33);
    end

    // Random pairs: check the division identity and R < B.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == '0) rb = 32'd1;
      run($sformatf("rnd%0d", i), ra, rb, ra / rb, ra % rb, 1'b0, 33);
      chk($sformatf("rnd%0d_ident", i), 64'(bus.Q) * 64'(rb) + 64'(bus.R), 64'(ra));
      chk($sformatf("rnd%0d_rlt", i), 64'(bus.R < rb), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/div_gen_1.md
# div_gen_1

Sequential unsigned integer divider that inverts the shift-add multiplier in the arithmetic unit. It computes quotient and remainder of two WIDTH-bit unsigned operands with a radix-2 restoring algorithm, one quotient bit per clock. It sits beside the multiplier in the execute stage and shares its start/operand style. A stall controller consumes `busy`/`done`.

## Interface

Parameters:
- `WIDTH`, 32, operand, quotient and remainder width; legal range 4..64.

Ports:
- `CLK`  in  1  rising-edge clock; the block uses one clock only.
- `RESETN`  in  1  asynchronous, active-low reset.
- `div`  in  1  start request, sampled on the rising edge of `CLK`.
- `A`  in  WIDTH  dividend, captured when a start is accepted.
- `B`  in  WIDTH  divisor, captured when a start is accepted.
- `Q`  out  WIDTH  quotient, registered.
- `R`  out  WIDTH  remainder, registered.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse; `Q`/`R` are valid on this cycle.
- `dbz`  out  1  divide-by-zero flag, valid with `done`.

## Operation

- FSM states: IDLE, CALC, FIN.
- IDLE:
  - `div`=1 with `B`≠0: capture `A` into the quotient/shift register, `B` into the divisor register, clear the WIDTH+1-bit partial remainder, load count=WIDTH, go to CALC.
  - `div`=1 with `B`=0: go directly to FIN with Q=all-ones, R=A, dbz=1.
- CALC, each cycle:
  - rem' = {rem[WIDTH-1:0], qsh[WIDTH-1]}; qsh shifts left.
  - If rem' ≥ divisor: rem = rem' − divisor and the new qsh LSB = 1.
  - Else: rem = rem' and the new qsh LSB = 0.
  - Decrement count. When count reaches 1, this is the last step; go to FIN.
- FIN: drive `Q`=qsh and `R`=rem[WIDTH-1:0], pulse `done`, return to IDLE.
- `div` is accepted only in IDLE. A `div` asserted during CALC or FIN is ignored and has no queued effect.
- `Q`, `R` and `dbz` hold their values from the last completion until the next `done`. They do not change while CALC is in progress.
- Arithmetic is fully unsigned:
  - The remainder always satisfies R < B.
  - The invariant A = Q·B + R holds for every B≠0.
- A=0 gives Q=0, R=0. A<B gives Q=0, R=A. Neither case has a fast path; both take full latency.

## Timing

- Reset (RESETN=0, asynchronous, any state):
  - state=IDLE, count=0.
  - Q=0, R=0, busy=0, done=0, dbz=0.
  - All internal registers are cleared.
- Reset mid-CALC aborts the operation: no `done`, and outputs return to 0. Release is synchronous to `CLK`.
- Start accepted at edge 0, normal case:
  - `busy`=1 from edge 0 through edge WIDTH.
  - `done`=1 for the cycle after edge WIDTH+1 with `busy`=0.
  - Latency is WIDTH+1 cycles from accept to `done` (33 for WIDTH=32).
- Divide-by-zero: `done`=1 and `dbz`=1 after edge 1; `busy` stays 0.
- Back-to-back: the earliest new accept is the edge after `done` (IDLE). Maximum throughput is one division per WIDTH+2 cycles.
- `dbz` clears on the next normal completion.

## Structure

- Package `div_pkg`:
  - state enum `div_state_t` {IDLE, CALC, FIN}.
  - `DIV_WIDTH_DEFAULT`=32.
  - function `clog2` for the counter width ($clog2(WIDTH)+1 bits).
- Sub-module `div_step`: purely combinational single restoring iteration.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instanced once in the top. Keeps the datapath reusable for a later unrolled/radix-4 version.
- The top holds the FSM, counter and operand/result registers. Target size is roughly 150–250 lines.

## Test plan

1. A=100, B=7, `div` pulse at cycle 0 → `busy` for 32 cycles, `done` at cycle 33 with Q=14, R=2, dbz=0.
2. A=0xFFFFFFFF, B=1 → Q=0xFFFFFFFF, R=0. Then A=0xFFFFFFFF, B=0xFFFFFFFF → Q=1, R=0. Then A=3, B=10 → Q=0, R=3.
3. A=5, B=0 → `done` at cycle 1 with Q=0xFFFFFFFF, R=5, dbz=1, `busy` never high. A following 9/3 gives Q=3, R=0, dbz=0.
4. Start 1000/10; at cycle 5 pulse `div` with A=1, B=1 → ignored; result Q=100, R=0 at cycle 33. A new start the cycle after `done` is accepted.
5. Start 1000/10; assert RESETN=0 mid-cycle at cycle 12 → immediately Q=R=0, busy=0, no `done`. After release, 50/6 → Q=8, R=2.
6. 10k random (A,B) pairs with B≠0, including edge values 0, 1, 2^31, 2^32−1 → scoreboard checks A==Q·B+R, R<B, and the 33-cycle latency.
